// File: rtl/grant_arbiter16.sv
// rtl/grant_arbiter16.sv - round-robin 16-way arbiter with hold-time limit
//
// Shares one 16-way select between up to 16 requesters. A registered grant
// index/enable pair drives a 4-to-16 decoder directly. A matching one-hot
// grant is also provided. An optional hold limit forces rotation.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   req[15:0]  - request vector, bit i = requester i wants the resource
//   release_in - current holder is finished (only looked at while granting)
//   grant_idx  - index of the current holder (decoder select)
//   grant_en   - a grant is active (decoder enable)
//   grant      - one-hot grant, 1 << grant_idx while grant_en, else 0
//   timeout    - one-cycle pulse in the gap after a hold-limit revoke

module grant_arbiter16 #(
   parameter int HOLD_MAX = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic        release_in,
   output logic [3:0]  grant_idx,
   output logic        grant_en,
   output logic [15:0] grant,
   output logic        timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
   localparam logic       LIM_EN   = (HOLD_MAX != 0);

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  grant_idx_q, grant_idx_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic        timeout_q, timeout_d;

   logic [3:0]  sel_idx;
   logic [3:0]  cand;
   logic        found;
   logic        limit_hit;

   // Rotating priority search: first set request at ptr, ptr+1, ... with
   // 4-bit wrap-around doing the modulo-16.
   always_comb begin
      found   = 1'b0;
      sel_idx = ptr_q;
      cand    = 4'd0;
      for (int i = 0; i < 16; i++) begin
         cand = ptr_q + 4'(i);
         if (!found && req[cand]) begin
            found   = 1'b1;
            sel_idx = cand;
         end
      end
   end

   assign limit_hit = LIM_EN && (hold_cnt_q == HOLD_LIM);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_idx_d = grant_idx_q;
      hold_cnt_d  = hold_cnt_q;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_idx_d = sel_idx;
               hold_cnt_d  = 8'd1;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (!req[grant_idx_q] || release_in || limit_hit) begin
               // Always pass through IDLE so consecutive owners never abut.
               state_d   = IDLE;
               ptr_d     = grant_idx_q + 4'd1;
               timeout_d = limit_hit;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 4'd0;
         grant_idx_q <= 4'd0;
         hold_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_idx_q <= grant_idx_d;
         hold_cnt_q  <= hold_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign grant_idx = grant_idx_q;
   assign grant_en  = (state_q == GRANT);
   assign grant     = grant_en ? (16'h0001 << grant_idx_q) : 16'h0000;
   assign timeout   = timeout_q;

endmodule

// File: doc/grant_arbiter16.md
# grant_arbiter16

- Round-robin arbiter that shares one 16-way resource select between up to 16 requesters.
- Its registered 4-bit grant index and enable drive the `decoder4to16` select directly (`grant_idx` → `in`, `grant_en` → `enable`).
- It also provides a matching one-hot grant vector and a hold-time limit that forces rotation, so no requester can starve the others.
- Targets the Artix-7 lab board: switches/buttons as requesters, LEDs showing the one-hot grant.

## Interface

Parameters:
- `HOLD_MAX`, default 255: maximum consecutive cycles one requester may hold the grant. The value 0 disables the limit. Range 0..255 (8-bit counter).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `req`  input  16  request vector; bit i high means requester i wants the resource.
- `release`  input  1  the current holder is finished; sampled only in GRANT.
- `grant_idx`  output  4  index of the current holder; connects to the decoder `in`.
- `grant_en`  output  1  a grant is active; connects to the decoder `enable`.
- `grant`  output  16  one-hot grant, equal to 1 << `grant_idx` when `grant_en` = 1, else 0.
- `timeout`  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation

Two-state FSM: IDLE and GRANT.

State (registers):
- `state`
- `ptr` (4-bit, highest-priority position for the next arbitration)
- `grant_idx`
- `hold_cnt` (8-bit)
- `timeout`

IDLE:
- If `req` = 0: stay in IDLE.
- Otherwise select the first set bit of `req`, scanning `ptr`, `ptr`+1, …, wrapping from 15 to 0.
- Load `grant_idx` with that index, set `hold_cnt` = 1, go to GRANT.

GRANT is left when any of these holds, checked on each rising edge:
- `req[grant_idx]` = 0 (requester withdrew);
- `release` = 1;
- `HOLD_MAX` ≠ 0 and `hold_cnt` = `HOLD_MAX` (forced revoke; `timeout` = 1 in the following cycle).

Otherwise stay in GRANT and increment `hold_cnt`.

On leaving GRANT:
- Go to IDLE and set `ptr` = `grant_idx` + 1 (mod 16, 15 wraps to 0).
- IDLE always lasts at least one cycle after a grant. This gap cycle guarantees that two grants never overlap or abut, so the decoder output goes all-zero between owners.

Outputs:
- `grant_en` = (state == GRANT).
- `grant` is decoded from the registered `grant_idx` and gated by `grant_en`. It is glitch-free relative to `grant_idx`.
- `timeout` is registered: high for exactly the gap cycle that follows a forced revoke, otherwise 0.

Boundary rules:
- `release` and withdrawal in the same cycle are a single leave event; `timeout` stays 0 unless the hold limit was also reached.
- If the hold limit and `release` coincide, `timeout` = 1; the limit takes precedence for reporting.
- The holder may re-request immediately. It competes at the lowest priority because `ptr` has moved past it.
- A single active requester with `HOLD_MAX` = N gets N cycles of grant, 1 gap cycle, then a new grant, repeating.
- `release` while in IDLE is ignored.
- Requests that change while in GRANT do not affect the current grant.

## Timing

Reset (async assert, synchronous-edge deassert handled upstream):
- `state` = IDLE, `ptr` = 0, `grant_idx` = 0, `hold_cnt` = 0.
- `grant_en` = 0, `grant` = 16'h0000, `timeout` = 0.
- Outputs drop immediately on `rst`, even mid-grant.

Latency:
- A request sampled at edge k (arbiter in IDLE) produces `grant_en` = 1 after edge k.
- Grant duration in cycles equals `hold_cnt` at exit.
- Release sampled at edge k drops `grant_en` after edge k.
- The earliest next grant appears after edge k+1 (one gap cycle).

Worst-case wait for requester i with all 16 requesting and `HOLD_MAX` = H: 15 × (H+1) + 1 cycles.

## Test plan

- Reset, then `req` = 16'h0000 for 10 cycles → `grant_en` = 0, `grant` = 16'h0000, `timeout` = 0 throughout. Assert `rst` mid-grant → all outputs 0 asynchronously, and the next grant starts from `ptr` = 0.
- `req` = 16'h0011 held, each holder releases after 3 cycles → grants alternate idx 0, 4, 0, 4, …; each grant lasts 3 cycles with a 1-cycle all-zero gap; `grant` = 16'h0001 / 16'h0010.
- `req` = 16'hFFFF, `release` pulsed every 2nd grant cycle → grant_idx sequence 0,1,…,15,0 (wrap-around); no index is repeated before all 16 have been served.
- `HOLD_MAX` = 4, `req` = 16'h0100 held, `release` = 0 → idx 8 granted for 4 cycles, then a gap cycle with `timeout` = 1, then regranted; the pattern repeats.
- Holder idx 2 drops `req[2]` while `req[9]` rises in the same cycle → 1 gap cycle, then grant idx 9 (`ptr` = 3 skips to 9), `timeout` = 0.
- `release` = 1 in IDLE with `req` = 0 → no state change. Then `req[15]` only → grant idx 15; after release, `ptr` = 0.
